// File: rtl/shift_exec_unit.sv
// Multi-cycle shift execution stage: accepts one shift micro-op, shifts up to
// STEP positions per cycle, and hands the result to writeback over valid/ready.
module shift_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  // One extra bit so STEP == WIDTH is representable.
  localparam logic [SHAMT_W:0] STEP_W  = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_W = (SHAMT_W+1)'(WIDTH);

  logic [1:0]         state_q,    state_d;
  logic [WIDTH-1:0]   work_q,     work_d;
  logic [SHAMT_W-1:0] rem_q,      rem_d;
  logic [1:0]         op_q,       op_d;
  logic               sign_q,     sign_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;

  logic [SHAMT_W:0]   k;
  logic [WIDTH-1:0]   fill_mask;
  logic [WIDTH-1:0]   step_res;

  // Partial shift of the work register by k = min(STEP, rem).
  always_comb begin
    k         = ({1'b0, rem_q} > STEP_W) ? STEP_W : {1'b0, rem_q};
    fill_mask = ~({WIDTH{1'b1}} >> k);
    case (op_q)
      OP_SLL:  step_res = work_q << k;
      OP_SRL:  step_res = work_q >> k;
      OP_SRA:  step_res = (work_q >> k) | (sign_q ? fill_mask : '0);
      OP_ROL:  step_res = (work_q << k) | (work_q >> (WIDTH_W - k));
      default: step_res = work_q;
    endcase
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    rem_d      = rem_q;
    op_d       = op_q;
    sign_d     = sign_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d = in_data;
          rem_d  = in_shamt;
          op_d   = in_op;
          sign_d = in_data[WIDTH-1];
          if (in_shamt == '0) begin
            state_d    = S_DONE;
            out_data_d = in_data;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = step_res;
        rem_d  = rem_q - k[SHAMT_W-1:0];
        if ({1'b0, rem_q} == k) begin
          state_d    = S_DONE;
          out_data_d = step_res;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      rem_q      <= '0;
      op_q       <= OP_SLL;
      sign_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      op_q       <= op_d;
      sign_q     <= sign_d;
      out_data_q <= out_data_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;

endmodule
